// File: rtl/winograd_tile_sequencer.sv
// ---------------------------------------------------------------------------
// winograd_tile_sequencer
//
// Address/control sequencer for the Winograd convolution engine. After an
// accepted start it streams the whole transformed kernel set out of kernel
// SRAM. It then walks every output tile position (row-major) and, for each
// position, every input channel. Each (tile, channel) pair gets one
// TILE x TILE activation window read. The PE array is pulsed once each
// window has fully arrived, and the sequencer waits for the save unit after
// the last channel of a tile.
//
// Optional feature: define SEQ_ZERO_PAD_EN to surround the activation plane
// with a zero border PAD wide. Border slots are not read from SRAM. Instead
// they are flagged on act_zero so the PE substitutes zero.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle request, only honoured while idle
//   cfg_*           run configuration, captured when start is accepted
//   ker_addr/en     kernel SRAM read port
//   act_addr/en     activation SRAM read port
//   act_zero        current window slot is padding
//   pe_ready        PE array can take a new window
//   pe_start        window complete, compute (with pe_first_ch/pe_last_ch)
//   save_done       save unit has stored the tile result
//   busy, done      run in progress / one-cycle completion pulse
//   err             sticky bad-configuration flag, cleared by the next start
// ---------------------------------------------------------------------------
module winograd_tile_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int DIM_W    = 8,
  parameter int CH_W     = 4,
  parameter int TILE     = 6,
  parameter int SRAM_LAT = 1,
  parameter int PAD      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_act_size,
  input  logic [DIM_W-1:0]  cfg_stride,
  input  logic [CH_W-1:0]   cfg_channels,
  input  logic [ADDR_W-1:0] cfg_ker_words,
  input  logic [ADDR_W-1:0] cfg_act_base,
  input  logic [ADDR_W-1:0] cfg_ch_pitch,
  input  logic [ADDR_W-1:0] cfg_ker_base,
  output logic [ADDR_W-1:0] ker_addr,
  output logic              ker_en,
  output logic [ADDR_W-1:0] act_addr,
  output logic              act_en,
  output logic              act_zero,
  input  logic              pe_ready,
  output logic              pe_start,
  output logic              pe_first_ch,
  output logic              pe_last_ch,
  input  logic              save_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Coordinates live in padded space, so they need headroom beyond DIM_W.
  localparam int EW         = DIM_W + 2;
  localparam int KW         = ADDR_W + CH_W;
  localparam int IW         = $clog2(TILE + 1);
  localparam int LW         = $clog2(SRAM_LAT + 1) + 1;
  localparam int DRAIN_LAST = (SRAM_LAT > 0) ? SRAM_LAT - 1 : 0;

`ifdef SEQ_ZERO_PAD_EN
  localparam int PAD_EFF = PAD;
`else
  // Padding compiled out: the border collapses to zero width.
  localparam int PAD_EFF = PAD - PAD;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KER,
    WAIT_PE,
    LOAD_WIN,
    DRAIN,
    FIRE,
    WAIT_SAVE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]  act_size_q, stride_q;
  logic [EW-1:0]     edge_q;
  logic [CH_W-1:0]   channels_q, ch_q;
  logic [ADDR_W-1:0] act_base_q, ch_pitch_q, row_step_q, pad_off_q;
  logic [ADDR_W-1:0] ch_base_q, row_off_q, slot_row_q, ker_addr_q;
  logic [KW-1:0]     ker_total_q, ker_cnt_q;
  logic [EW-1:0]     r_q, c_q;
  logic [IW-1:0]     i_q, j_q;
  logic [LW-1:0]     drain_q;
  logic              err_q;

  logic [EW-1:0] cfg_edge;
  logic          cfg_bad;
  logic          last_ker, last_slot, last_ch, drain_end;
  logic          col_more, row_more, more_tiles;
  logic          slot_pad;

  // Configuration sanity check, evaluated on the raw inputs at start so
  // the verdict is ready when the first busy cycle begins.
  assign cfg_edge = EW'(cfg_act_size) + EW'(2 * PAD_EFF);
  assign cfg_bad  = (cfg_stride == '0) || (cfg_channels == '0) ||
                    (cfg_ker_words == '0) || (cfg_edge < EW'(TILE));

  assign last_ker  = (ker_cnt_q == ker_total_q - KW'(1));
  assign last_slot = (i_q == IW'(TILE - 1)) && (j_q == IW'(TILE - 1));
  assign last_ch   = (ch_q == channels_q - CH_W'(1));
  assign drain_end = (drain_q == LW'(DRAIN_LAST));

  // A further tile fits only if its whole window stays inside the edge.
  // This avoids a divider for the tile count.
  assign col_more   = (c_q + EW'(stride_q) + EW'(TILE)) <= edge_q;
  assign row_more   = (r_q + EW'(stride_q) + EW'(TILE)) <= edge_q;
  assign more_tiles = col_more || row_more;

`ifdef SEQ_ZERO_PAD_EN
  logic [EW-1:0] prow, pcol;

  // A slot is padding when its padded coordinate lies in the border ring.
  assign prow     = r_q + EW'(i_q);
  assign pcol     = c_q + EW'(j_q);
  assign slot_pad = (prow < EW'(PAD_EFF)) ||
                    (prow >= EW'(PAD_EFF) + EW'(act_size_q)) ||
                    (pcol < EW'(PAD_EFF)) ||
                    (pcol >= EW'(PAD_EFF) + EW'(act_size_q));
`else
  assign slot_pad = 1'b0;
`endif

  // The address is built from running offsets rather than multipliers.
  // pad_off shifts padded coordinates back onto the unpadded plane.
  assign act_addr = ch_base_q + row_off_q + slot_row_q + ADDR_W'(c_q) +
                    ADDR_W'(j_q) - pad_off_q;
  assign ker_addr = ker_addr_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE) && (state_q != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ker_en      = 1'b0;
    act_en      = 1'b0;
    act_zero    = 1'b0;
    pe_start    = 1'b0;
    pe_first_ch = 1'b0;
    pe_last_ch  = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_KER;
      end
      LOAD_KER: begin
        // A rejected configuration passes through here with no reads.
        if (err_q) begin
          state_d = DONE;
        end else begin
          ker_en = 1'b1;
          if (last_ker) state_d = WAIT_PE;
        end
      end
      WAIT_PE: begin
        if (pe_ready) state_d = LOAD_WIN;
      end
      LOAD_WIN: begin
        act_en   = !slot_pad;
        act_zero = slot_pad;
        if (last_slot) state_d = (SRAM_LAT == 0) ? FIRE : DRAIN;
      end
      DRAIN: begin
        if (drain_end) state_d = FIRE;
      end
      FIRE: begin
        pe_start    = 1'b1;
        pe_first_ch = (ch_q == '0);
        pe_last_ch  = last_ch;
        state_d     = last_ch ? WAIT_SAVE : WAIT_PE;
      end
      WAIT_SAVE: begin
        if (save_done) state_d = more_tiles ? WAIT_PE : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: configuration capture plus the kernel, slot, channel and tile
  // counters. Each counter advances only in the state that consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_size_q  <= '0;
      stride_q    <= '0;
      edge_q      <= '0;
      channels_q  <= '0;
      act_base_q  <= '0;
      ch_pitch_q  <= '0;
      row_step_q  <= '0;
      pad_off_q   <= '0;
      ker_total_q <= '0;
      err_q       <= 1'b0;
      ker_addr_q  <= '0;
      ker_cnt_q   <= '0;
      ch_q        <= '0;
      ch_base_q   <= '0;
      r_q         <= '0;
      c_q         <= '0;
      row_off_q   <= '0;
      i_q         <= '0;
      j_q         <= '0;
      slot_row_q  <= '0;
      drain_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            act_size_q  <= cfg_act_size;
            stride_q    <= cfg_stride;
            edge_q      <= cfg_edge;
            channels_q  <= cfg_channels;
            act_base_q  <= cfg_act_base;
            ch_pitch_q  <= cfg_ch_pitch;
            row_step_q  <= ADDR_W'(cfg_stride) * ADDR_W'(cfg_act_size);
            pad_off_q   <= ADDR_W'(PAD_EFF) * ADDR_W'(cfg_act_size) +
                           ADDR_W'(PAD_EFF);
            ker_total_q <= KW'(cfg_ker_words) * KW'(cfg_channels);
            err_q       <= cfg_bad;
            ker_addr_q  <= cfg_ker_base;
            ker_cnt_q   <= '0;
            ch_q        <= '0;
            ch_base_q   <= cfg_act_base;
            r_q         <= '0;
            c_q         <= '0;
            row_off_q   <= '0;
            i_q         <= '0;
            j_q         <= '0;
            slot_row_q  <= '0;
            drain_q     <= '0;
          end
        end
        LOAD_KER: begin
          if (!err_q) begin
            ker_addr_q <= ker_addr_q + ADDR_W'(1);
            ker_cnt_q  <= ker_cnt_q + KW'(1);
          end
        end
        LOAD_WIN: begin
          if (last_slot) begin
            i_q        <= '0;
            j_q        <= '0;
            slot_row_q <= '0;
          end else if (j_q == IW'(TILE - 1)) begin
            j_q        <= '0;
            i_q        <= i_q + IW'(1);
            slot_row_q <= slot_row_q + ADDR_W'(act_size_q);
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        DRAIN: begin
          drain_q <= drain_end ? '0 : drain_q + LW'(1);
        end
        FIRE: begin
          if (!last_ch) begin
            ch_q      <= ch_q + CH_W'(1);
            ch_base_q <= ch_base_q + ch_pitch_q;
          end
        end
        WAIT_SAVE: begin
          if (save_done && more_tiles) begin
            ch_q      <= '0;
            ch_base_q <= act_base_q;
            if (col_more) begin
              c_q <= c_q + EW'(stride_q);
            end else begin
              c_q       <= '0;
              r_q       <= r_q + EW'(stride_q);
              row_off_q <= row_off_q + row_step_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_winograd_tile_sequencer
//
// Directed bench for winograd_tile_sequencer. A negedge monitor logs every
// kernel read, activation slot and PE pulse, and it also acts as the save
// unit (save_done three cycles after pe_last_ch). The main sequence runs
// the directed cases and compares the logs with hand values and with a
// small reference walk of the tile/channel/slot order.
// ---------------------------------------------------------------------------
module tb_winograd_tile_sequencer;

`ifdef SEQ_ZERO_PAD_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int ERR_SIZE = 5 - 2 * P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_act_size, cfg_stride;
  logic [3:0]  cfg_channels;
  logic [15:0] cfg_ker_words, cfg_act_base, cfg_ch_pitch, cfg_ker_base;
  logic [15:0] ker_addr, act_addr;
  logic        ker_en, act_en, act_zero;
  logic        pe_ready, pe_start, pe_first_ch, pe_last_ch;
  logic        save_done, busy, done, err;

  int checks   = 0;
  int failures = 0;

  logic [16:0] act_log[$];
  logic [16:0] exp_log[$];
  logic [1:0]  pe_log[$];
  int          ker_cnt, ker_bad, read_cnt, zero_cnt, overlap, done_cnt;
  int          save_cnt;
  logic [15:0] ker_base_exp;

  winograd_tile_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_act_size(cfg_act_size), .cfg_stride(cfg_stride),
    .cfg_channels(cfg_channels), .cfg_ker_words(cfg_ker_words),
    .cfg_act_base(cfg_act_base), .cfg_ch_pitch(cfg_ch_pitch),
    .cfg_ker_base(cfg_ker_base),
    .ker_addr(ker_addr), .ker_en(ker_en),
    .act_addr(act_addr), .act_en(act_en), .act_zero(act_zero),
    .pe_ready(pe_ready), .pe_start(pe_start),
    .pe_first_ch(pe_first_ch), .pe_last_ch(pe_last_ch),
    .save_done(save_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor and save-unit model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      save_cnt  = 0;
      save_done = 1'b0;
    end else begin
      if (ker_en) begin
        if (ker_addr !== 16'(ker_base_exp + 16'(ker_cnt))) ker_bad++;
        ker_cnt++;
      end
      if (act_en) begin
        act_log.push_back({1'b0, act_addr});
        read_cnt++;
      end
      if (act_zero) begin
        act_log.push_back({1'b1, 16'h0});
        zero_cnt++;
      end
      if ((ker_en && act_en) || (act_en && act_zero)) overlap++;
      if (pe_start && (ker_en || act_en)) overlap++;
      if (pe_start) pe_log.push_back({pe_first_ch, pe_last_ch});
      if (done) done_cnt++;
      if (pe_start && pe_last_ch) begin
        save_cnt  = 3;
        save_done = 1'b0;
      end else if (save_cnt != 0) begin
        save_cnt--;
        save_done = (save_cnt == 0);
      end else begin
        save_done = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearLog();
    act_log.delete();
    pe_log.delete();
    ker_cnt  = 0;
    ker_bad  = 0;
    read_cnt = 0;
    zero_cnt = 0;
    overlap  = 0;
    done_cnt = 0;
  endtask

  task automatic applyStimulus(input int size, input int stride, input int nch,
                               input int kw, input int base, input int pitch,
                               input int kbase);
    clearLog();
    @(negedge clk); #1;
    cfg_act_size  = 8'(size);
    cfg_stride    = 8'(stride);
    cfg_channels  = 4'(nch);
    cfg_ker_words = 16'(kw);
    cfg_act_base  = 16'(base);
    cfg_ch_pitch  = 16'(pitch);
    cfg_ker_base  = 16'(kbase);
    ker_base_exp  = 16'(kbase);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    // Scramble the configuration: the running job must not see this.
    cfg_act_size  = 8'd7;
    cfg_stride    = 8'd1;
    cfg_channels  = 4'd5;
    cfg_ker_words = 16'd3;
    cfg_act_base  = 16'hDEAD;
    cfg_ch_pitch  = 16'h1111;
    cfg_ker_base  = 16'hBEEF;
  endtask

  task automatic waitDone(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput(tag, done_cnt, 1);
  endtask

  // Reference walk: tile row, tile column, channel, slot row, slot column.
  task automatic buildModel(input int size, input int stride, input int nch,
                            input int base, input int pitch);
    int edge_len = size + 2 * P;
    int n = (edge_len - 6) / stride + 1;
    exp_log.delete();
    for (int tr = 0; tr < n; tr++)
      for (int tc = 0; tc < n; tc++)
        for (int ch = 0; ch < nch; ch++)
          for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
              int pr = tr * stride + i;
              int pc = tc * stride + j;
              if (pr < P || pr >= P + size || pc < P || pc >= P + size)
                exp_log.push_back({1'b1, 16'h0});
              else
                exp_log.push_back({1'b0, 16'(base + ch * pitch +
                                   (pr - P) * size + (pc - P))});
            end
  endtask

  task automatic compareLog(input string tag);
    int mism = 0;
    checkOutput({tag, "_slots"}, act_log.size(), exp_log.size());
    for (int k = 0; k < act_log.size() && k < exp_log.size(); k++)
      if (act_log[k] !== exp_log[k]) mism++;
    checkOutput({tag, "_slot_mism"}, mism, 0);
    checkOutput({tag, "_ker_addr_bad"}, ker_bad, 0);
    checkOutput({tag, "_enable_overlap"}, overlap, 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; pe_ready = 1'b1; save_done = 1'b0;
    cfg_act_size = '0; cfg_stride = '0; cfg_channels = '0;
    cfg_ker_words = '0; cfg_act_base = '0; cfg_ch_pitch = '0;
    cfg_ker_base = '0; ker_base_exp = '0; save_cnt = 0;
    clearLog();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ker_en", ker_en, 0);
    checkOutput("rst_act_en", act_en, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_act_addr", act_addr, 0);
    checkOutput("rst_ker_addr", ker_addr, 0);
    rst_n = 1'b1;

    // Case 1: 10x10, stride 4, one channel.
    $display("[TB] case 1: 10x10 stride 4 single channel");
    applyStimulus(10, 4, 1, 36, 16'h1000, 0, 16'h0200);
    waitDone("c1_done");
    buildModel(10, 4, 1, 16'h1000, 0);
    compareLog("c1");
    checkOutput("c1_ker_reads", ker_cnt, 36);
    checkOutput("c1_pe_pulses", pe_log.size(), 4);
    checkOutput("c1_pe_flags", (pe_log.size() == 4) ?
                {pe_log[0], pe_log[1], pe_log[2], pe_log[3]} : 8'h0, 8'hFF);
    checkOutput("c1_err", err, 0);
`ifndef SEQ_ZERO_PAD_EN
    checkOutput("c1_act_reads", read_cnt, 144);
    if (act_log.size() == 144) begin
      checkOutput("c1_addr0", act_log[0], 17'h1000);
      checkOutput("c1_addr6", act_log[6], 17'h1000 + 10);
      checkOutput("c1_addr35", act_log[35], 17'h1000 + 55);
      checkOutput("c1_tile1_addr0", act_log[36], 17'h1000 + 4);
      checkOutput("c1_addr143", act_log[143], 17'h1000 + 99);
    end
`endif

    // Case 2: three channels, pitch 100.
    $display("[TB] case 2: 6x6 three channels");
    applyStimulus(6, 4, 3, 36, 16'h2000, 100, 16'h0000);
    waitDone("c2_done");
    buildModel(6, 4, 3, 16'h2000, 100);
    compareLog("c2");
    checkOutput("c2_ker_reads", ker_cnt, 108);
    checkOutput("c2_pe_flags", (pe_log.size() == 3) ?
                {pe_log[0], pe_log[1], pe_log[2]} : 6'h3F, 6'b10_00_01);
`ifndef SEQ_ZERO_PAD_EN
    if (act_log.size() == 108) begin
      checkOutput("c2_win0", act_log[0], 17'h2000);
      checkOutput("c2_win1", act_log[36], 17'h2000 + 100);
      checkOutput("c2_win2", act_log[72], 17'h2000 + 200);
    end
`endif

    // Case 3: PE stall before the second channel.
    $display("[TB] case 3: pe_ready stall");
    applyStimulus(6, 4, 2, 4, 16'h3000, 50, 16'h0100);
    k = 0;
    while (pe_log.size() == 0 && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput("c3_first_fire", pe_log.size(), 1);
    pe_ready = 1'b0;
    k = act_log.size();
    repeat (20) @(negedge clk);
    #1;
    checkOutput("c3_stall_no_reads", act_log.size(), k);
    checkOutput("c3_stall_busy", busy, 1);
    pe_ready = 1'b1;
    @(negedge clk); #1;
`ifndef SEQ_ZERO_PAD_EN
    checkOutput("c3_resume_en", act_en, 1);
    checkOutput("c3_resume_addr", act_addr, 16'h3000 + 50);
`else
    checkOutput("c3_resume_zero", act_zero, 1);
`endif
    waitDone("c3_done");
    buildModel(6, 4, 2, 16'h3000, 50);
    compareLog("c3");

    // Case 4: bad configurations.
    $display("[TB] case 4: bad configuration");
    applyStimulus(10, 0, 1, 36, 16'h1000, 0, 16'h0200);
    checkOutput("c4a_busy", busy, 1);
    checkOutput("c4a_err", err, 1);
    checkOutput("c4a_no_early_done", done, 0);
    @(negedge clk); #1;
    checkOutput("c4a_done", done, 1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("c4a_reads", ker_cnt + read_cnt + zero_cnt, 0);
    checkOutput("c4a_err_sticky", err, 1);
    applyStimulus(ERR_SIZE, 4, 1, 36, 16'h1000, 0, 16'h0200);
    @(negedge clk); #1;
    checkOutput("c4b_done", done, 1);
    checkOutput("c4b_err", err, 1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("c4b_reads", ker_cnt + read_cnt + zero_cnt, 0);

    // Case 5: reset in the middle of a window.
    $display("[TB] case 5: reset mid window");
    applyStimulus(10, 4, 1, 36, 16'h1000, 0, 16'h0200);
    k = 0;
    while (read_cnt < 10 && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput("c5_reached_window", read_cnt, 10);
    rst_n = 1'b0;
    #1;
    checkOutput("c5_rst_busy", busy, 0);
    checkOutput("c5_rst_act_en", act_en, 0);
    checkOutput("c5_rst_act_addr", act_addr, 0);
    checkOutput("c5_rst_ker_addr", ker_addr, 0);
    checkOutput("c5_rst_pe_start", pe_start, 0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("c5_no_done", done_cnt, 0);
    applyStimulus(6, 4, 3, 36, 16'h2000, 100, 16'h0000);
    waitDone("c5_rerun_done");
    buildModel(6, 4, 3, 16'h2000, 100);
    compareLog("c5_rerun");
    checkOutput("c5_rerun_ker", ker_cnt, 108);

`ifdef SEQ_ZERO_PAD_EN
    // Case 6: 4x4 plane with a one-wide zero border.
    $display("[TB] case 6: zero padding");
    applyStimulus(4, 4, 1, 9, 16'h4000, 0, 16'h0000);
    waitDone("c6_done");
    buildModel(4, 4, 1, 16'h4000, 0);
    compareLog("c6");
    checkOutput("c6_zero_slots", zero_cnt, 20);
    checkOutput("c6_reads", read_cnt, 16);
    if (act_log.size() == 36) begin
      checkOutput("c6_first_read", act_log[7], 17'h4000);
      checkOutput("c6_last_read", act_log[28], 17'h4000 + 15);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
